chess_move_engine: RTL and testbench

//  Parametrised successor of the chess layout matrix: holds the board, cursor and lock state.

---
 rtl/chess_move_if.sv | 43 ++++
 rtl/chess_move_engine.sv | 217 +++++++++++++++++++++
 tb/tb_chess_move_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/chess_move_if.sv
`default_nettype none
// chess_move_if: tick/key/lock inputs and board/status outputs of chess_move_engine.
// Move-log signals exist only when CHESS_MOVE_LOG_EN is defined.
interface chess_move_if #(
  parameter int BOARD_FILES  = 8,
  parameter int BOARD_RANKS  = 8,
  parameter int SQUARE_WIDTH = 8
);
  logic StepTick;
  logic KeyLeft;
  logic KeyRight;
  logic KeyUp;
  logic KeyDown;
  logic LockSwitch;
  logic [BOARD_FILES*BOARD_RANKS*SQUARE_WIDTH-1:0] Layout;
  logic Player;
  logic Busy;
  logic MoveDone;
  logic MoveReject;
`ifdef CHESS_MOVE_LOG_EN
  localparam int IDX_WIDTH = $clog2(BOARD_FILES*BOARD_RANKS);
  logic [IDX_WIDTH-1:0] LastSrc;
  logic [IDX_WIDTH-1:0] LastDst;
  logic [3:0]           LastCapt;
`endif

  modport master (
    output StepTick, KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch,
    input  Layout, Player, Busy, MoveDone, MoveReject
`ifdef CHESS_MOVE_LOG_EN
    , input LastSrc, LastDst, LastCapt
`endif
  );

  modport slave (
    input  StepTick, KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch,
    output Layout, Player, Busy, MoveDone, MoveReject
`ifdef CHESS_MOVE_LOG_EN
    , output LastSrc, LastDst, LastCapt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/chess_move_engine.sv
`default_nettype none
// chess_move_engine: board/cursor/lock state, sequential path-scan move validator and commit.
// Reset image is the standard opening position; CHESS_MOVE_LOG_EN adds LastSrc/LastDst/LastCapt.
module chess_move_engine #(
  parameter int BOARD_FILES  = 8,
  parameter int BOARD_RANKS  = 8,
  parameter int SQUARE_WIDTH = 8,
  parameter int COORD_WIDTH  = 3,
  parameter int CURSOR_X0    = 2,
  parameter int CURSOR_Y0    = 3
) (
  input  wire logic   clock,
  input  wire logic   resetApp_n,
  chess_move_if.slave bus
);
  localparam int NSQ      = BOARD_FILES * BOARD_RANKS;
  localparam int IDXW     = $clog2(NSQ);
  localparam int CW       = COORD_WIDTH;
  localparam int DW       = COORD_WIDTH + 1;
  localparam int CUR0_IDX = CURSOR_Y0 * BOARD_FILES + CURSOR_X0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOCKED = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_REJECT = 3'd5;

  logic [2:0]           r_state, w_next;
  logic [3:0]           r_board [NSQ];
  logic [SQUARE_WIDTH-1:0] r_lay [NSQ];
  logic [CW-1:0]        r_cx, r_cy, r_sx, r_sy, r_tx, r_ty;
  logic signed [DW-1:0] r_px, r_py;
  logic                 r_player;

  function automatic logic [3:0] f_init_sq(input int i);
    int         x, y;
    logic [2:0] p;
    logic [3:0] sq;
    x = i % BOARD_FILES;
    y = i / BOARD_FILES;
    case (x % 8)
      0, 7:    p = 3'd3;
      1, 6:    p = 3'd2;
      2, 5:    p = 3'd4;
      3:       p = 3'd5;
      default: p = 3'd6;
    endcase
    sq = 4'h0;
    if (y == 0)                    sq = {1'b0, p};
    else if (y == 1)               sq = 4'h1;
    else if (y == BOARD_RANKS - 2) sq = 4'h9;
    else if (y == BOARD_RANKS - 1) sq = {1'b1, p};
    return sq;
  endfunction

  function automatic logic [IDXW-1:0] f_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return IDXW'(int'(y) * BOARD_FILES + int'(x));
  endfunction

  logic [IDXW-1:0] w_cur_idx, w_src_idx, w_dst_idx, w_ptr_idx;
  logic [3:0]      w_cur_sq, w_src_sq, w_dst_sq;
  logic [2:0]      w_ptr_piece;
  assign w_cur_idx   = f_idx(r_cx, r_cy);
  assign w_src_idx   = f_idx(r_sx, r_sy);
  assign w_dst_idx   = f_idx(r_tx, r_ty);
  assign w_ptr_idx   = f_idx(r_px[CW-1:0], r_py[CW-1:0]);
  assign w_cur_sq    = r_board[w_cur_idx];
  assign w_src_sq    = r_board[w_src_idx];
  assign w_dst_sq    = r_board[w_dst_idx];
  assign w_ptr_piece = r_board[w_ptr_idx][2:0];

  logic signed [DW-1:0] w_ddx, w_ddy, w_stx, w_sty, w_pnx, w_pny, w_fwd, w_fwd2;
  logic [DW-1:0]        w_adx, w_ady, w_dist;
  logic [CW-1:0]        w_start;
  assign w_ddx  = $signed({1'b0, r_tx}) - $signed({1'b0, r_sx});
  assign w_ddy  = $signed({1'b0, r_ty}) - $signed({1'b0, r_sy});
  assign w_adx  = w_ddx[DW-1] ? $unsigned(-w_ddx) : $unsigned(w_ddx);
  assign w_ady  = w_ddy[DW-1] ? $unsigned(-w_ddy) : $unsigned(w_ddy);
  assign w_dist = (w_adx > w_ady) ? w_adx : w_ady;
  assign w_stx  = (w_ddx == '0) ? '0 : (w_ddx[DW-1] ? '1 : DW'(1));
  assign w_sty  = (w_ddy == '0) ? '0 : (w_ddy[DW-1] ? '1 : DW'(1));
  assign w_pnx  = r_px + w_stx;
  assign w_pny  = r_py + w_sty;
  // White advances toward rank 0, black toward RANKS-1.
  assign w_fwd   = w_src_sq[3] ? '1 : DW'(1);
  assign w_fwd2  = w_fwd + w_fwd;
  assign w_start = w_src_sq[3] ? CW'(BOARD_RANKS - 2) : CW'(1);

  logic w_dst_occ, w_own, w_same, w_rook, w_bishop, w_pawn2, w_legal, w_need_scan, w_scan_end;
  assign w_dst_occ  = |w_dst_sq[2:0];
  assign w_own      = w_dst_occ && (w_dst_sq[3] == w_src_sq[3]);
  assign w_same     = (w_src_idx == w_dst_idx);
  assign w_rook     = (w_adx == '0) != (w_ady == '0);
  assign w_bishop   = (w_adx == w_ady) && (w_adx != '0);
  assign w_pawn2    = (w_ddx == '0) && (w_ddy == w_fwd2) && (r_sy == w_start) && !w_dst_occ;
  assign w_scan_end = (w_pnx == $signed({1'b0, r_tx})) && (w_pny == $signed({1'b0, r_ty}));

  always_comb begin
    w_legal     = 1'b0;
    w_need_scan = 1'b0;
    case (w_src_sq[2:0])
      3'd1: begin
        w_legal = ((w_ddx == '0) && (w_ddy == w_fwd) && !w_dst_occ) || w_pawn2 ||
                  ((w_adx == DW'(1)) && (w_ddy == w_fwd) && w_dst_occ);
        w_need_scan = w_pawn2;
      end
      3'd2: w_legal = ((w_adx == DW'(1)) && (w_ady == DW'(2))) ||
                      ((w_adx == DW'(2)) && (w_ady == DW'(1)));
      3'd3: begin w_legal = w_rook;              w_need_scan = (w_dist > DW'(1)); end
      3'd4: begin w_legal = w_bishop;            w_need_scan = (w_dist > DW'(1)); end
      3'd5: begin w_legal = w_rook || w_bishop;  w_need_scan = (w_dist > DW'(1)); end
      3'd6: w_legal = (w_dist == DW'(1));
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.StepTick && bus.LockSwitch && (|w_cur_sq[2:0]) && (w_cur_sq[3] == r_player))
                  w_next = S_LOCKED;
      S_LOCKED: if (bus.StepTick && !bus.LockSwitch) w_next = S_CHECK;
      S_CHECK:  if (w_same || w_own || !w_legal) w_next = S_REJECT;
                else if (w_need_scan)           w_next = S_SCAN;
                else                            w_next = S_COMMIT;
      S_SCAN:   if (|w_ptr_piece)    w_next = S_REJECT;
                else if (w_scan_end) w_next = S_COMMIT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Busy       = 1'b0;
    bus.MoveDone   = 1'b0;
    bus.MoveReject = 1'b0;
    case (r_state)
      S_CHECK, S_SCAN: bus.Busy = 1'b1;
      S_COMMIT: begin bus.Busy = 1'b1; bus.MoveDone = 1'b1; end
      S_REJECT: bus.MoveReject = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      r_cx <= CW'(CURSOR_X0);  r_cy <= CW'(CURSOR_Y0);
      r_sx <= '0;  r_sy <= '0;  r_tx <= '0;  r_ty <= '0;
      r_px <= '0;  r_py <= '0;
      r_player <= 1'b1;
    end else begin
      if (bus.StepTick && (r_state == S_IDLE || r_state == S_LOCKED)) begin
        if (!bus.KeyLeft)       begin if (r_cx != '0) r_cx <= r_cx - 1'b1; end
        else if (!bus.KeyRight) begin if (r_cx != CW'(BOARD_FILES - 1)) r_cx <= r_cx + 1'b1; end
        else if (!bus.KeyUp)    begin if (r_cy != '0) r_cy <= r_cy - 1'b1; end
        else if (!bus.KeyDown)  begin if (r_cy != CW'(BOARD_RANKS - 1)) r_cy <= r_cy + 1'b1; end
      end
      if (r_state == S_IDLE && w_next == S_LOCKED)  begin r_sx <= r_cx; r_sy <= r_cy; end
      if (r_state == S_LOCKED && w_next == S_CHECK) begin r_tx <= r_cx; r_ty <= r_cy; end
      if (r_state == S_CHECK) begin
        r_px <= $signed({1'b0, r_sx}) + w_stx;
        r_py <= $signed({1'b0, r_sy}) + w_sty;
      end
      if (r_state == S_SCAN) begin r_px <= w_pnx; r_py <= w_pny; end
      if (r_state == S_COMMIT) r_player <= ~r_player;
    end
  end

  for (genvar i = 0; i < NSQ; i++) begin : g_square
    localparam logic [IDXW-1:0] SQ_IDX = IDXW'(i);
    logic w_is_cur, w_locked;
    assign w_is_cur = (w_cur_idx == SQ_IDX);
    assign w_locked = (r_state == S_LOCKED);

    always_ff @(posedge clock or negedge resetApp_n) begin
      if (!resetApp_n) begin
        r_board[i] <= f_init_sq(i);
      end else if (r_state == S_COMMIT) begin
        if (SQ_IDX == w_dst_idx)      r_board[i] <= w_src_sq;
        else if (SQ_IDX == w_src_idx) r_board[i] <= 4'h0;
      end
    end

    always_ff @(posedge clock or negedge resetApp_n) begin
      if (!resetApp_n)
        r_lay[i] <= SQUARE_WIDTH'({3'b000, (i == CUR0_IDX), f_init_sq(i)});
      else
        r_lay[i] <= SQUARE_WIDTH'({1'b0, w_locked && w_is_cur, w_locked && (SQ_IDX == w_src_idx),
                                   !w_locked && w_is_cur, r_board[i]});
    end

    assign bus.Layout[i*SQUARE_WIDTH +: SQUARE_WIDTH] = r_lay[i];
  end

  assign bus.Player = r_player;

`ifdef CHESS_MOVE_LOG_EN
  logic [IDXW-1:0] r_last_src, r_last_dst;
  logic [3:0]      r_last_capt;
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      r_last_src <= '0;  r_last_dst <= '0;  r_last_capt <= '0;
    end else if (r_state == S_COMMIT) begin
      r_last_src <= w_src_idx;  r_last_dst <= w_dst_idx;  r_last_capt <= w_dst_sq;
    end
  end
  assign bus.LastSrc  = r_last_src;
  assign bus.LastDst  = r_last_dst;
  assign bus.LastCapt = r_last_capt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_chess_move_engine.sv
`default_nettype none
// tb_chess_move_engine: directed checks of reset image, cursor clamping, pawn/rook/bishop moves
// and reset-abort on the 8x8 default chess_move_engine.
module tb_chess_move_engine;
  localparam int F  = 8;
  localparam int R  = 8;
  localparam int SW = 8;
  localparam int LW = F * R * SW;

  logic clock = 1'b0;
  logic resetApp_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cx, cy;
  logic [3:0] eb [64];

  always #5 clock = ~clock;

  chess_move_if #(.BOARD_FILES(F), .BOARD_RANKS(R), .SQUARE_WIDTH(SW)) bus ();

  chess_move_engine #(
    .BOARD_FILES(F), .BOARD_RANKS(R), .SQUARE_WIDTH(SW),
    .COORD_WIDTH(3), .CURSOR_X0(2), .CURSOR_Y0(3)
  ) dut (
    .clock      (clock),
    .resetApp_n (resetApp_n),
    .bus        (bus)
  );

  function automatic logic [3:0] init_sq(input int i);
    int x, y;
    logic [2:0] p;
    x = i % 8;
    y = i / 8;
    case (x)
      0, 7:    p = 3'd3;
      1, 6:    p = 3'd2;
      2, 5:    p = 3'd4;
      3:       p = 3'd5;
      default: p = 3'd6;
    endcase
    if (y == 0) return {1'b0, p};
    if (y == 1) return 4'h1;
    if (y == 6) return 4'h9;
    if (y == 7) return {1'b1, p};
    return 4'h0;
  endfunction

  function automatic logic [LW-1:0] flat(input int cur);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < 64; i++)
      v[i*8 +: 8] = {4'h0, eb[i]} | ((i == cur) ? 8'h10 : 8'h00);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tick(input logic l, input logic r, input logic u, input logic d);
    @(negedge clock);
    bus.KeyLeft = ~l;  bus.KeyRight = ~r;  bus.KeyUp = ~u;  bus.KeyDown = ~d;
    bus.StepTick = 1'b1;
    @(negedge clock);
    bus.StepTick = 1'b0;
    bus.KeyLeft = 1'b1;  bus.KeyRight = 1'b1;  bus.KeyUp = 1'b1;  bus.KeyDown = 1'b1;
  endtask

  task automatic goto_sq(input int tx, input int ty);
    while (cx > tx) begin tick(1, 0, 0, 0); cx--; end
    while (cx < tx) begin tick(0, 1, 0, 0); cx++; end
    while (cy > ty) begin tick(0, 0, 1, 0); cy--; end
    while (cy < ty) begin tick(0, 0, 0, 1); cy++; end
  endtask

  task automatic lock_piece();
    bus.LockSwitch = 1'b1;
    tick(0, 0, 0, 0);
  endtask

  // Drop at the cursor, then watch a fixed window; optional reset on window cycle abort_at.
  task automatic drop_watch(input int abort_at, output int busy_n, output int done_n, output int rej_n);
    @(negedge clock);
    bus.LockSwitch = 1'b0;
    bus.StepTick   = 1'b1;
    @(negedge clock);
    bus.StepTick = 1'b0;
    busy_n = 0;  done_n = 0;  rej_n = 0;
    for (int k = 0; k < 10; k++) begin
      busy_n += int'(bus.Busy);
      done_n += int'(bus.MoveDone);
      rej_n  += int'(bus.MoveReject);
      if (k == abort_at) resetApp_n = 1'b0;
      @(negedge clock);
    end
    if (abort_at >= 0) begin
      resetApp_n = 1'b1;
      cx = 2;  cy = 3;
      for (int i = 0; i < 64; i++) eb[i] = init_sq(i);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetApp_n = 1'b0;
    bus.LockSwitch = 1'b0;
    wait_clk(2);
    resetApp_n = 1'b1;
    cx = 2;  cy = 3;
    for (int i = 0; i < 64; i++) eb[i] = init_sq(i);
  endtask

  initial begin
    int busy_n, done_n, rej_n;
    logic [LW-1:0] e;
    bus.StepTick = 1'b0;
    bus.KeyLeft = 1'b1;  bus.KeyRight = 1'b1;  bus.KeyUp = 1'b1;  bus.KeyDown = 1'b1;
    bus.LockSwitch = 1'b0;
    resetApp_n = 1'b0;
    wait_clk(3);
    do_reset();
    wait_clk(1);

    chk("reset_layout", bus.Layout, flat(26));
    chk("reset_player", LW'(bus.Player), LW'(1));
    chk("reset_busy", LW'(bus.Busy), LW'(0));
    chk("reset_done", LW'(bus.MoveDone), LW'(0));
    chk("reset_reject", LW'(bus.MoveReject), LW'(0));

    goto_sq(0, 6);
    repeat (3) tick(1, 0, 0, 0);
    wait_clk(2);
    chk("clamp_left", bus.Layout, flat(48));
    goto_sq(7, 6);
    repeat (2) tick(0, 1, 0, 0);
    wait_clk(2);
    chk("clamp_right", bus.Layout, flat(55));

    goto_sq(4, 6);
    lock_piece();
    wait_clk(2);
    e = flat(-1);
    e[52*8 +: 8] = 8'h69;
    chk("locked_src", bus.Layout, e);
    goto_sq(4, 4);
    wait_clk(2);
    e[52*8 +: 8] = 8'h29;
    e[36*8 +: 8] = 8'h40;
    chk("locked_cursor", bus.Layout, e);
    drop_watch(-1, busy_n, done_n, rej_n);
    eb[52] = 4'h0;  eb[36] = 4'h9;
    chk("pawn2_busy", LW'(busy_n), LW'(3));
    chk("pawn2_done", LW'(done_n), LW'(1));
    chk("pawn2_reject", LW'(rej_n), LW'(0));
    chk("pawn2_layout", bus.Layout, flat(36));
    chk("pawn2_player", LW'(bus.Player), LW'(0));

    do_reset();
    goto_sq(0, 7);
    lock_piece();
    goto_sq(0, 4);
    drop_watch(-1, busy_n, done_n, rej_n);
    chk("rook_busy", LW'(busy_n), LW'(2));
    chk("rook_reject", LW'(rej_n), LW'(1));
    chk("rook_done", LW'(done_n), LW'(0));
    chk("rook_layout", bus.Layout, flat(32));
    chk("rook_player", LW'(bus.Player), LW'(1));

    do_reset();
    goto_sq(3, 6);
    lock_piece();
    goto_sq(3, 4);
    drop_watch(-1, busy_n, done_n, rej_n);
    eb[51] = 4'h0;  eb[35] = 4'h9;
    chk("open_pawn_done", LW'(done_n), LW'(1));
    goto_sq(0, 1);
    lock_piece();
    goto_sq(0, 2);
    drop_watch(-1, busy_n, done_n, rej_n);
    eb[8] = 4'h0;  eb[16] = 4'h1;
    chk("black_pawn_busy", LW'(busy_n), LW'(2));
    chk("black_pawn_done", LW'(done_n), LW'(1));
    goto_sq(2, 7);
    lock_piece();
    goto_sq(5, 4);
    drop_watch(-1, busy_n, done_n, rej_n);
    eb[58] = 4'h0;  eb[37] = 4'hC;
    chk("bishop_busy", LW'(busy_n), LW'(4));
    chk("bishop_done", LW'(done_n), LW'(1));
    chk("bishop_layout", bus.Layout, flat(37));
    chk("bishop_player", LW'(bus.Player), LW'(0));
`ifdef CHESS_MOVE_LOG_EN
    chk("log_src", LW'(bus.LastSrc), LW'(58));
    chk("log_dst", LW'(bus.LastDst), LW'(37));
    chk("log_capt", LW'(bus.LastCapt), LW'(0));
`endif

    goto_sq(1, 1);
    lock_piece();
    goto_sq(1, 3);
    drop_watch(1, busy_n, done_n, rej_n);
    wait_clk(2);
    chk("abort_done", LW'(done_n), LW'(0));
    chk("abort_layout", bus.Layout, flat(26));
    chk("abort_player", LW'(bus.Player), LW'(1));
    chk("abort_busy", LW'(bus.Busy), LW'(0));
`ifdef CHESS_MOVE_LOG_EN
    chk("abort_log_src", LW'(bus.LastSrc), LW'(0));
    chk("abort_log_dst", LW'(bus.LastDst), LW'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
